// File: rtl/aes_byte_decrypt_ctrl.sv
// Byte-serial AES-128 decrypt front end: gathers key and ciphertext bytes, lets
// the combinational inverse cipher settle for DEC_WAIT cycles, then streams plaintext.
module aes_decrypt (
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic [127:0] pt
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] mcoef(input int k);
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-8*(j+4*c) -: 8], mcoef((j - r + 4) % 4));
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] c, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s, u;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]) ^ rc, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = c ^ {w[40], w[41], w[42], w[43]};
    u = '0;
    for (int r = 9; r >= 0; r--) begin
      // inverse shift rows fused with inverse sub bytes
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          u[127-8*(row+4*col) -: 8] = isbox(s[127-8*(row+4*((col-row+4)%4)) -: 8]);
      s = u ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r != 0) s = inv_mix(s);
    end
    return s;
  endfunction

  always_comb pt = aes_dec(ct, key);
endmodule

module aes_byte_decrypt_ctrl #(
  parameter int DEC_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_sel,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       key_valid,
  output logic       busy
);
  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_SEND} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(DEC_WAIT - 1);

  state_t       state_q, state_d;
  logic [3:0]   kcnt_q, kcnt_d, dcnt_q, dcnt_d, wcnt_q, wcnt_d, ocnt_q, ocnt_d;
  logic [127:0] key_q, key_d, ct_q, ct_d, pt_q, pt_d;
  logic         key_valid_q, key_valid_d;
  logic         rdy_en_q;
  logic [127:0] pt_dec;
  logic         key_in, ct_in;

  aes_decrypt u_dec (.ct(ct_q), .key(key_q), .pt(pt_dec));

  // rdy_en_q holds in_ready low through the first clock after reset
  assign in_ready  = rdy_en_q && (state_q == ST_LOAD) &&
                     (in_sel ? (dcnt_q == 4'd0) : key_valid_q);
  assign out_valid = (state_q == ST_SEND);
  assign out_data  = pt_q[127:120];
  assign key_valid = key_valid_q;
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_SEND);
  assign key_in    = in_valid && in_ready && in_sel;
  assign ct_in     = in_valid && in_ready && !in_sel;

  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    dcnt_d      = dcnt_q;
    wcnt_d      = wcnt_q;
    ocnt_d      = ocnt_q;
    key_d       = key_q;
    ct_d        = ct_q;
    pt_d        = pt_q;
    key_valid_d = key_valid_q;
    if (clear) begin
      state_d = ST_LOAD;
      dcnt_d  = 4'd0;
      ocnt_d  = 4'd0;
      wcnt_d  = 4'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (key_in) begin
            key_d  = {key_q[119:0], in_data};
            kcnt_d = kcnt_q + 4'd1;
            if (kcnt_q == 4'd0)  key_valid_d = 1'b0;
            if (kcnt_q == 4'd15) key_valid_d = 1'b1;
          end
          if (ct_in) begin
            ct_d   = {ct_q[119:0], in_data};
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q == 4'd15) begin
              state_d = ST_WAIT;
              wcnt_d  = WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd0) begin
            wcnt_d  = 4'd0;
            pt_d    = pt_dec;
            ocnt_d  = 4'd0;
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            pt_d   = {pt_q[119:0], 8'h00};
            ocnt_d = ocnt_q + 4'd1;
            if (ocnt_q == 4'd15) state_d = ST_LOAD;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      kcnt_q      <= '0;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      ocnt_q      <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      pt_q        <= '0;
      key_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      ocnt_q      <= ocnt_d;
      key_q       <= key_d;
      ct_q        <= ct_d;
      pt_q        <= pt_d;
      key_valid_q <= key_valid_d;
      rdy_en_q    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_byte_decrypt_ctrl.sv
// Directed + randomized bench: plaintexts are encrypted by a byte-array AES model
// and the DUT must stream the original plaintext back.
module tb_aes_byte_decrypt_ctrl;
  localparam int DW = 4;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

  logic       clk = 0, rst = 1, clear = 0, in_sel = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, out_valid, key_valid, busy;
  logic [7:0] out_data;
  logic [7:0] sb [256];
  int         n_chk = 0, n_pass = 0;

  aes_byte_decrypt_ctrl #(.DEC_WAIT(DW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_sel(in_sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .key_valid(key_valid), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward AES-128 over byte arrays; the DUT must invert it.
  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] rk [176];
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] t [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[127-8*i -: 8];
      st[i] = pt[127-8*i -: 8] ^ rk[i];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = rk[i-4+j];
      if (i % 16 == 0) begin
        t[0] = sb[rk[i-3]] ^ rc; t[1] = sb[rk[i-2]];
        t[2] = sb[rk[i-1]];      t[3] = sb[rk[i-4]];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ t[j];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) tmp[rw+4*c] = sb[st[rw+4*((c+rw)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (rnd < 10) begin
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = st[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic sel, input logic [7:0] d);
    int n;
    n = 0;
    in_sel = sel; in_data = d; in_valid = 1; #1;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      n_chk++;
      $error("FAIL send_timeout: in_ready never rose for sel=%0d", sel);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_block(input logic sel, input logic [127:0] v);
    for (int i = 0; i < 16; i++) send_byte(sel, v[127-8*i -: 8]);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
  endtask

  // mode 0: always ready, 1: one cycle on / two off, 2: random
  task automatic recv_block(input int mode, input int maxb, output logic [127:0] pt,
                            output int nb, output bit stable);
    int cyc; logic [7:0] held; bit holding;
    pt = '0; nb = 0; stable = 1; holding = 0; cyc = 0;
    while (nb < maxb && cyc < 400) begin
      case (mode)
        0:       out_ready = 1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (holding && (!out_valid || out_data !== held)) stable = 0;
      if (out_valid && out_ready) begin
        pt = {pt[119:0], out_data}; nb++; holding = 0;
      end else if (out_valid) begin
        holding = 1; held = out_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 0;
  endtask

  initial begin
    logic [7:0] p, q, x;
    logic [127:0] got, rkey, rpt;
    int lat, nb;
    bit stable;

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0}; q = q ^ {q[5:0], 2'b0}; q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;

    // reset state
    in_sel = 1; #3;
    chk("rst_outs", {in_ready, out_valid, key_valid, busy, out_data}, 12'h0);
    tick(); rst = 0; #1;
    chk("rdy_before_clk", in_ready, 0);
    tick();
    chk("rdy_key_after_clk", in_ready, 1);

    // ciphertext refused without key, then with a partial key
    in_sel = 0; in_valid = 1; in_data = 8'hab;
    for (int i = 0; i < 4; i++) begin
      #1; chk("ct_refused_nokey", in_ready, 0); tick();
    end
    in_valid = 0;
    chk("nokey_idle", {busy, key_valid}, 0);
    for (int i = 0; i < 10; i++) send_byte(1, K1[127-8*i -: 8]);
    in_sel = 0; #1;
    chk("ct_refused_partial", {in_ready, key_valid}, 0);
    for (int i = 10; i < 16; i++) send_byte(1, K1[127-8*i -: 8]);
    chk("key_valid_full", key_valid, 1);

    // known vector, latency, free-flowing output
    send_block(0, C1);
    chk("wait_busy", {busy, out_valid}, 2'b10);
    wait_valid(lat);
    chk("latency", lat, DW);
    recv_block(0, 16, got, nb, stable);
    chk("pt_known", got, P1);
    chk("nbytes_known", nb, 16);
    chk("valid_drops", {out_valid, busy, key_valid}, 3'b001);

    // 1-on/2-off backpressure
    send_block(0, C1);
    wait_valid(lat);
    recv_block(1, 16, got, nb, stable);
    chk("pt_stall", got, P1);
    chk("stall_stable", stable, 1);
    chk("stall_no_dup", out_valid, 0);

    // back-to-back, same key
    for (int b = 0; b < 2; b++) begin
      send_block(0, C1);
      wait_valid(lat);
      recv_block(0, 16, got, nb, stable);
      chk("pt_b2b", got, P1);
    end

    // randomized keys, plaintexts and backpressure
    for (int it = 0; it < 4; it++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      send_byte(1, rkey[127:120]);
      chk("reload_kv_low", key_valid, 0);
      for (int i = 1; i < 16; i++) send_byte(1, rkey[127-8*i -: 8]);
      chk("rand_key_valid", key_valid, 1);
      send_block(0, enc(rkey, rpt));
      wait_valid(lat);
      chk("rand_latency", lat, DW);
      recv_block(2, 16, got, nb, stable);
      chk("rand_pt", got, rpt);
      chk("rand_stable", stable, 1);
    end

    // key refused mid-block, clear beats a simultaneous ct byte
    send_block(1, K1);
    for (int i = 0; i < 8; i++) send_byte(0, C1[127-8*i -: 8]);
    in_sel = 1; in_valid = 1; #1;
    chk("key_refused_midct", in_ready, 0);
    in_sel = 0; in_data = 8'h5a; clear = 1;
    tick();
    clear = 0; in_valid = 0; in_sel = 1; #1;
    chk("clear_dcnt0", {in_ready, busy, key_valid}, 3'b101);
    send_block(0, C1);
    wait_valid(lat);
    recv_block(0, 16, got, nb, stable);
    chk("pt_after_clear", got, P1);

    // reset during SEND after 5 bytes
    send_block(0, C1);
    wait_valid(lat);
    recv_block(0, 5, got, nb, stable);
    chk("partial_bytes", got[39:0], P1[127:88]);
    rst = 1; #1;
    chk("rst_mid_send", {out_valid, key_valid, busy}, 0);
    tick(); rst = 0; tick();
    in_sel = 0; #1;
    chk("ct_refused_after_rst", in_ready, 0);
    send_block(1, K1);
    send_block(0, C1);
    wait_valid(lat);
    recv_block(0, 16, got, nb, stable);
    chk("pt_after_rst", got, P1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
